// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Two-requester round-robin burst arbiter for an async FIFO write port
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter #(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_last,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req1_last,
    output logic             req1_ready,
    input  logic             fifo_full,
    input  logic             fifo_almost_full,
    output logic             fifo_wen,
    output logic [WIDTH-1:0] fifo_wdata,
    output logic [1:0]       grant,
    output logic             busy,
    output logic [15:0]      words_written
);

    localparam int              c_CW       = $clog2(BURST) + 1;
    localparam logic [c_CW-1:0] c_BEAT_MAX = c_CW'(BURST - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_GNT0 = 2'd1;
    localparam logic [1:0] c_GNT1 = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [c_CW-1:0] r_beat_cnt;
    logic            r_last_srv;
    logic [15:0]     r_words_written;
    logic            w_sel_valid;
    logic            w_sel_last;

    assign w_sel_valid = (r_state == c_GNT0) ? req0_valid :
                         (r_state == c_GNT1) ? req1_valid : 1'b0;
    assign w_sel_last  = (r_state == c_GNT0) ? req0_last :
                         (r_state == c_GNT1) ? req1_last : 1'b0;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; almost_full only gates the start of a burst
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (!fifo_almost_full) begin
                    if (req0_valid && req1_valid) begin
                        w_next_state = r_last_srv ? c_GNT0 : c_GNT1;
                    end else if (req0_valid) begin
                        w_next_state = c_GNT0;
                    end else if (req1_valid) begin
                        w_next_state = c_GNT1;
                    end
                end
            end
            c_GNT0, c_GNT1: begin
                if (fifo_wen) begin
                    if (w_sel_last || (r_beat_cnt == c_BEAT_MAX)) begin
                        w_next_state = c_IDLE;
                    end
                end else if (!w_sel_valid) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // Outputs are forced low while reset is held, even mid-burst
    always_comb begin
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        fifo_wen      = 1'b0;
        fifo_wdata    = '0;
        grant         = 2'b00;
        busy          = 1'b0;
        words_written = 16'd0;
        if (!rst) begin
            words_written = r_words_written;
            busy          = (r_state != c_IDLE);
            grant         = {r_state == c_GNT1, r_state == c_GNT0};
            case (r_state)
                c_GNT0: begin
                    req0_ready = ~fifo_full;
                    fifo_wen   = req0_valid & ~fifo_full;
                    fifo_wdata = req0_data;
                end
                c_GNT1: begin
                    req1_ready = ~fifo_full;
                    fifo_wen   = req1_valid & ~fifo_full;
                    fifo_wdata = req1_data;
                end
                default: ;
            endcase
        end
    end

    // Beat counter, round-robin memory and write counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt      <= '0;
            r_last_srv      <= 1'b1;
            r_words_written <= 16'd0;
        end else begin
            if ((r_state == c_IDLE) && (w_next_state != c_IDLE)) begin
                r_beat_cnt <= '0;
            end else if (fifo_wen) begin
                r_beat_cnt <= r_beat_cnt + c_CW'(1);
            end
            if ((r_state != c_IDLE) && (w_next_state == c_IDLE)) begin
                r_last_srv <= (r_state == c_GNT1);
            end
            r_words_written <= r_words_written + {15'd0, fifo_wen};
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Scoreboard bench for fifo_wr_arbiter with a behavioural grant model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

    localparam int WIDTH = 8;
    localparam int BURST = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       bv = 2'b00;
    logic [1:0]       bl = 2'b00;
    logic [WIDTH-1:0] bd [2];
    logic             b_full = 1'b0;
    logic             b_af = 1'b0;

    logic             req0_ready, req1_ready, fifo_wen, busy;
    logic [WIDTH-1:0] fifo_wdata;
    logic [1:0]       grant;
    logic [15:0]      words_written;

    fifo_wr_arbiter #(.WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk              (clk),
        .rst              (rst),
        .req0_valid       (bv[0]),
        .req0_data        (bd[0]),
        .req0_last        (bl[0]),
        .req0_ready       (req0_ready),
        .req1_valid       (bv[1]),
        .req1_data        (bd[1]),
        .req1_last        (bl[1]),
        .req1_ready       (req1_ready),
        .fifo_full        (b_full),
        .fifo_almost_full (b_af),
        .fifo_wen         (fifo_wen),
        .fifo_wdata       (fifo_wdata),
        .grant            (grant),
        .busy             (busy),
        .words_written    (words_written)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Pending source words {last, data} and words issued but not yet written
    logic [8:0]       src_q [2][$];
    logic [WIDTH-1:0] exp_q [2][$];
    logic [1:0]       acc = 2'b00;
    logic [1:0]       stream = 2'b00;
    int               gap_pct = 0;
    bit               rand_mode = 1'b0;
    bit               force_req = 1'b0;

    // Reference model: current owner (-1 = nobody), beats in burst, last served
    int          m_owner = -1;
    int          m_beats = 0;
    int          m_last  = 1;
    logic [15:0] m_count = 16'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit f, input bit a);
        logic [8:0] w;
        @(negedge clk);
        rst = r;
        for (int x = 0; x < 2; x++) begin
            if (!(bv[x] && !acc[x])) begin
                if (src_q[x].size() == 0 && stream[x]) begin
                    src_q[x].push_back({1'b0, 8'($urandom)});
                end
                if (src_q[x].size() != 0 && (int'($urandom_range(99)) >= gap_pct)) begin
                    w = src_q[x].pop_front();
                    bv[x] = 1'b1;
                    bl[x] = w[8];
                    bd[x] = w[7:0];
                    exp_q[x].push_back(w[7:0]);
                end else begin
                    bv[x] = 1'b0;
                    bl[x] = 1'b0;
                end
            end
        end
        if (rand_mode) begin
            b_full = ($urandom_range(99) < 15);
            b_af   = ($urandom_range(99) < 20);
        end else begin
            b_full = f;
            b_af   = a;
        end
        if (force_req) begin
            force dut.r_words_written = 16'hFFFF;
            m_count   = 16'hFFFF;
            force_req = 1'b0;
            #1;
            release dut.r_words_written;
            #3;
        end else begin
            #4;
        end
        acc[0] = bv[0] & req0_ready;
        acc[1] = bv[1] & req1_ready;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (i < 300 && (src_q[0].size() != 0 || src_q[1].size() != 0 ||
                           exp_q[0].size() != 0 || exp_q[1].size() != 0 || bv != 2'b00)) begin
            step(1'b0, 1'b0, 1'b0);
            i++;
        end
        n_checks++;
        if (i >= 300) begin
            n_err++;
            $display("FAIL drain at %0t: words left req0=%0d req1=%0d required 0", $time,
                     exp_q[0].size(), exp_q[1].size());
        end
        repeat (2) step(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every write must carry the oldest outstanding word of the owner
    always begin
        logic [WIDTH-1:0] e;
        @(negedge clk);
        #1;
        if (fifo_wen) begin
            if (m_owner < 0 || exp_q[m_owner].size() == 0) begin
                chk("unexpected_write", {31'd0, fifo_wen}, 32'd0);
            end else begin
                e = exp_q[m_owner].pop_front();
                chk("wdata", {24'd0, fifo_wdata}, {24'd0, e});
            end
        end
    end

    // Model: predicts per-cycle outputs from the arbitration rules, then advances
    always begin
        logic [1:0]       e_grant;
        logic             e_busy, e_r0, e_r1, e_wen;
        logic [WIDTH-1:0] e_wdata;
        logic [15:0]      e_ww;
        @(negedge clk);
        #2;
        e_grant = 2'b00; e_busy = 1'b0; e_r0 = 1'b0; e_r1 = 1'b0;
        e_wen = 1'b0; e_wdata = '0; e_ww = 16'd0;
        if (!rst) begin
            e_ww = m_count;
            if (m_owner >= 0) begin
                e_busy  = 1'b1;
                e_grant = (m_owner == 0) ? 2'b01 : 2'b10;
                e_r0    = (m_owner == 0) && !b_full;
                e_r1    = (m_owner == 1) && !b_full;
                e_wen   = bv[m_owner] && !b_full;
                e_wdata = bd[m_owner];
            end
        end
        chk("grant", {30'd0, grant}, {30'd0, e_grant});
        chk("busy", {31'd0, busy}, {31'd0, e_busy});
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, e_r0});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, e_r1});
        chk("fifo_wen", {31'd0, fifo_wen}, {31'd0, e_wen});
        chk("fifo_wdata", {24'd0, fifo_wdata}, {24'd0, e_wdata});
        chk("words_written", {16'd0, words_written}, {16'd0, e_ww});

        if (rst) begin
            m_owner = -1; m_beats = 0; m_last = 1; m_count = 16'd0;
        end else if (m_owner < 0) begin
            if (!b_af && bv != 2'b00) begin
                if (bv == 2'b11) m_owner = 1 - m_last;
                else             m_owner = bv[0] ? 0 : 1;
                m_beats = 0;
            end
        end else if (e_wen) begin
            m_beats++;
            m_count = m_count + 16'd1;
            if (bl[m_owner] || m_beats == BURST) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end else if (!bv[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog at %0t: simulation did not complete", $time);
        $fatal(1);
    end

    initial begin
        bd[0] = '0;
        bd[1] = '0;

        // Reset with both requesters valid, then req0 burst of three and req1 single
        src_q[0].push_back(9'h011);
        src_q[0].push_back(9'h022);
        src_q[0].push_back(9'h133);
        src_q[1].push_back(9'h144);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        drain();

        // Continuous streams with no last: burst cap alternates the owners
        stream = 2'b11;
        repeat (30) step(1'b0, 1'b0, 1'b0);
        stream = 2'b00;
        drain();

        // Full stall after two beats of a four-beat burst
        for (int k = 0; k < 4; k++) src_q[0].push_back({k == 3, 8'h50 + 8'(k)});
        repeat (3) step(1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        drain();

        // Almost-full holds off the grant until it falls
        src_q[1].push_back(9'h1A5);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        drain();

        // Release after one word, then counter wrap at 0xFFFF
        src_q[0].push_back(9'h0AA);
        drain();
        force_req = 1'b1;
        src_q[1].push_back(9'h1BB);
        drain();

        // Reset in the middle of a burst
        for (int k = 0; k < 4; k++) src_q[0].push_back({1'b0, 8'h60 + 8'(k)});
        repeat (3) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        drain();

        // Randomised traffic, flags and occasional resets
        rand_mode = 1'b1;
        gap_pct   = 25;
        repeat (1500) begin
            for (int x = 0; x < 2; x++) begin
                if (src_q[x].size() < 3 && $urandom_range(1) == 1) begin
                    src_q[x].push_back({($urandom_range(3) == 0), 8'($urandom)});
                end
            end
            step(($urandom_range(99) == 0), 1'b0, 1'b0);
        end
        rand_mode = 1'b0;
        gap_pct   = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
